// File: rtl/skylark_pkg.sv
// Shared definitions for the execute-stage sequencer: datapath sizing,
// ALU operation codes and the sequencer state encoding.
package skylark_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RA_W = $clog2(NREG);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } exec_state_t;

endpackage

// File: rtl/alu_exec_seq_reg_file.sv
// Integer register file: two operand read ports, one debug read port and a
// single synchronous write port. x0 always reads zero and ignores writes.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [RA_W-1:0] rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    input  logic            wr_en,
    input  logic [RA_W-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem [NREG];

    // NOTE: the array is cleared on reset, so it maps to flops rather than a
    // RAM macro; the clear also wins over a write sampled on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer: latches one decoded ALU operation, drives the ALU
// for a settle cycle plus an execute cycle, writes back and returns the result.
module alu_exec_seq #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [RA_W-1:0] req_rs1,
    input  logic [RA_W-1:0] req_rs2,
    input  logic [RA_W-1:0] req_rd,
    input  logic [XLEN-1:0] req_imm,
    input  logic [2:0]      req_alu_control,
    input  logic            req_alu_src,
    input  logic            req_we,
    output logic [XLEN-1:0] srcA,
    output logic [XLEN-1:0] srcB_reg,
    output logic [XLEN-1:0] srcB_ImmExt,
    output logic [2:0]      ALUControl,
    output logic            ALUSrc,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            zero_in,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    import skylark_pkg::*;

    exec_state_t     state;
    exec_state_t     state_next;

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_reg;
    logic [XLEN-1:0] src_b_imm;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic [RA_W-1:0] rd_q;
    logic            we_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            accept;
    logic            wb_en;

    reg_file #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (req_rs1),
        .rs1_data (rs1_data),
        .rs2_addr (req_rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wb_en),
        .wr_addr  (rd_q),
        .wr_data  (ALUResult)
    );

    assign accept = req_valid && req_ready;
    assign wb_en  = (state == EXEC) && we_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: combinational blocks assign a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = OPER;
            OPER:    state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, even before the
    // first reset edge has settled the state register.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        if (rst_n) begin
            req_ready = (state == IDLE);
            rsp_valid = (state == RESP);
        end
    end

    // Drive registers load only on accept, so they keep their last values
    // once the operation has retired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_a     <= '0;
            src_b_reg <= '0;
            src_b_imm <= '0;
            alu_ctrl  <= '0;
            alu_src   <= 1'b0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            if (accept) begin
                src_a     <= rs1_data;
                src_b_reg <= rs2_data;
                src_b_imm <= req_imm;
                alu_ctrl  <= req_alu_control;
                alu_src   <= req_alu_src;
                rd_q      <= req_rd;
                we_q      <= req_we;
            end
            if (state == EXEC) begin
                result_q <= ALUResult;
                zero_q   <= zero_in;
            end
        end
    end

    assign srcA        = src_a;
    assign srcB_reg    = src_b_reg;
    assign srcB_ImmExt = src_b_imm;
    assign ALUControl  = alu_ctrl;
    assign ALUSrc      = alu_src;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer: the initiator side of the ALU operand/result interface.
- Accepts one decoded ALU operation per handshake and owns the integer register file.
- Drives srcA, srcB_reg, srcB_ImmExt, ALUControl and ALUSrc into the ALU, samples ALUResult and the zero flag, writes back rd, and returns the result on a response handshake.
- Sits between decode and the ALU in the core's execute stage.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; x0 hardwired to zero.
- RA_W, 5, register address width, equal to $clog2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  operation offered
- req_ready  out  1  sequencer can accept
- req_rs1  in  RA_W  source register A
- req_rs2  in  RA_W  source register B
- req_rd  in  RA_W  destination register
- req_imm  in  XLEN  sign-extended immediate
- req_alu_control  in  3  ALU operation code, passed through unchanged
- req_alu_src  in  1  1 = immediate operand B, 0 = register operand B
- req_we  in  1  write result to rd
- srcA  out  XLEN  ALU operand A
- srcB_reg  out  XLEN  ALU register operand B
- srcB_ImmExt  out  XLEN  ALU immediate operand B
- ALUControl  out  3  ALU operation
- ALUSrc  out  1  ALU operand-B select
- ALUResult  in  XLEN  ALU result, combinational from the drive ports
- zero_in  in  1  ALU zero flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  XLEN  captured ALUResult
- rsp_zero  out  1  captured zero flag
- dbg_addr  in  RA_W  debug read address
- dbg_data  out  XLEN  combinational register file read; 0 for x0

Behaviour:
- Reset: clock and reset are single-clock, synchronous active-low reset (rst_n sampled on rising clk).
  - While rst_n=0: all registers are cleared, state=IDLE, all ALU drive ports=0, rsp_valid=0, rsp_result=0, rsp_zero=0.
  - req_ready=0 while rst_n=0; req_ready=1 from the first cycle after release.
- FSM states: IDLE, OPER, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch rs2-independent fields (rd, we, imm, alu_control, alu_src) and register reads rf[rs1], rf[rs2] into the ALU drive registers. Next state OPER.
- OPER:
  - The ALU drive ports hold the latched operands.
  - One settle cycle. Next state EXEC.
- EXEC:
  - Drive ports unchanged.
  - At the end of the cycle, capture ALUResult into rsp_result and zero_in into rsp_zero.
  - If we=1 and rd!=0, write rf[rd]=ALUResult on the same edge.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_zero are held stable.
  - req_ready=0.
  - On rsp_ready=1: next state IDLE.
  - rsp_valid may stay high indefinitely under backpressure.
- Latency:
  - Accept edge at cycle 0; rsp_valid is high in cycle 3.
  - Minimum issue interval is 4 cycles.
- Drive ports keep their last values after leaving EXEC; they are not cleared to 0.
- x0:
  - Reads always return 0.
  - Writes to rd=0 are dropped, but rsp_result still reports ALUResult.
- Hazards: none. Writeback completes before the next accept, so back-to-back dependent operations read the updated value.
- Ignored inputs: req_valid outside IDLE is ignored; the request is not consumed.
- Reset mid-operation, any state: the operation is abandoned. No writeback occurs if the reset is sampled on the EXEC edge. The FSM returns to IDLE and the register file is cleared.
- Arithmetic: no arithmetic is performed here. All data fields are passed through at XLEN, unmodified.

Decomposition:
- Shared package skylark_pkg holds:
  - XLEN and the ALU operation codes; ALU_ADD = 3'b000.
  - The exec_state_t enum {IDLE, OPER, EXEC, RESP}.
- One sub-module, reg_file:
  - NREG x XLEN storage.
  - Two combinational read ports plus the debug read port.
  - One synchronous write port with x0 suppression.
  - Synchronous active-low clear.

Test Plan:
- The bench connects alu_exec_seq to the team ALU.
- Reset: rst_n=0 for 2 cycles -> req_ready=0, rsp_valid=0, all drive ports 0. After release, req_ready=1 and dbg_data=0 for every address.
- Immediate writeback:
  - Stimulus: rs1=0, imm=5, alu_src=1, alu_control=000, rd=1, we=1.
  - Response: srcB_ImmExt=5 and ALUSrc=1 in OPER; rsp_valid in cycle 3 with rsp_result=5, rsp_zero=0; dbg x1=5.
  - Repeat with imm=3, rd=2 -> x2=3.
- Register path, dependent back-to-back:
  - Stimulus: rs1=1, rs2=2, alu_src=0, ADD, rd=3.
  - Response: srcA=5, srcB_reg=3; rsp_result=8; dbg x3=8.
  - Next: rs1=3, rs2=3 -> 16.
- x0 handling:
  - rd=0, imm=7 -> rsp_result=7 and dbg x0 stays 0.
  - rs1=0, imm=0 -> rsp_result=0, rsp_zero=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_result stays constant, req_ready=0. A req_valid pulse during this time is not accepted. After rsp_ready=1, IDLE follows on the next cycle.
- Reset in EXEC: assert rst_n=0 while EXEC is active with rd=4, we=1 -> dbg x4=0, rsp_valid never rises, and req_ready=1 after release.
